// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer, display mux and input blocks:
// phase encoding, winner codes and the IR remote codes they all decode.
package game_pkg;

  typedef enum logic [2:0] {
    START     = 3'd0,
    COUNTDOWN = 3'd1,
    FIGHT     = 3'd2,
    PAUSED    = 3'd3,
    GAME_OVER = 3'd4
  } phase_t;

  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_PLAYER = 2'd1;
  localparam logic [1:0] WIN_OPP    = 2'd2;
  localparam logic [1:0] WIN_DRAW   = 2'd3;

  localparam logic [31:0] IR_CODE_START_A = 32'h20DF_5BA4;
  localparam logic [31:0] IR_CODE_START_B = 32'h20DF_5AA5;
  localparam logic [31:0] IR_CODE_PAUSE   = 32'h20DF_10EF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_phase_controller_if.sv
// Bundle of sequencer inputs (IR, frame strobe, health) and status outputs.
// master = surrounding game logic, slave = the phase controller.
interface game_phase_controller_if;
  import game_pkg::*;

  logic [31:0] ir_in;
  logic        ir_valid_in;
  logic        nf_in;
  logic [2:0]  player_health_in;
  logic [2:0]  opponent_health_in;
  phase_t      phase_out;
  logic        display_start_out;
  logic        play_enable_out;
  logic [1:0]  countdown_out;
  logic        health_reload_out;
  logic [1:0]  winner_out;

  modport master (
    output ir_in, ir_valid_in, nf_in, player_health_in, opponent_health_in,
    input  phase_out, display_start_out, play_enable_out, countdown_out,
           health_reload_out, winner_out
  );

  modport slave (
    input  ir_in, ir_valid_in, nf_in, player_health_in, opponent_health_in,
    output phase_out, display_start_out, play_enable_out, countdown_out,
           health_reload_out, winner_out
  );

endinterface

// File: rtl/frame_timer.sv
// Counts new-frame strobes; o_tc fires on the strobe that completes i_last+1 frames.
// The owner clears the count on every phase entry and on each terminal count.
module frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  assign o_tc = i_inc && (r_count == i_last);

  always_ff @(posedge clk_in) begin
    if (rst_in || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/game_phase_controller.sv
// Top-level game sequencer: start screen, countdown, fight, pause and game-over
// phases, driving display select, gameplay enable, health reload and winner.
module game_phase_controller
  import game_pkg::*;
#(
  parameter logic [31:0] IR_START_A       = IR_CODE_START_A,
  parameter logic [31:0] IR_START_B       = IR_CODE_START_B,
  parameter logic [31:0] IR_PAUSE         = IR_CODE_PAUSE,
  parameter int          COUNT_FROM       = 3,
  parameter int          FRAMES_PER_DIGIT = 60,
  parameter int          GAMEOVER_FRAMES  = 180
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  game_phase_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(FRAMES_PER_DIGIT, GAMEOVER_FRAMES)) + 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(FRAMES_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] GO_LAST    = CNT_W'(GAMEOVER_FRAMES - 1);
  localparam logic [1:0]       CD_INIT    = 2'(COUNT_FROM);

  phase_t     r_state;
  logic       r_display_start;
  logic       r_play_enable;
  logic [1:0] r_countdown;
  logic       r_health_reload;
  logic [1:0] r_winner;

  logic             w_start_ev;
  logic             w_pause_ev;
  logic             w_p_dead;
  logic             w_o_dead;
  logic             w_timer_inc;
  logic             w_timer_clr;
  logic             w_timer_tc;
  logic [CNT_W-1:0] w_timer_last;

  // A held ir_in only counts on the strobe cycle.
  assign w_start_ev = bus.ir_valid_in &&
                      ((bus.ir_in == IR_START_A) || (bus.ir_in == IR_START_B));
  assign w_pause_ev = bus.ir_valid_in && (bus.ir_in == IR_PAUSE);
  assign w_p_dead   = (bus.player_health_in == 3'd0);
  assign w_o_dead   = (bus.opponent_health_in == 3'd0);

  assign w_timer_inc  = bus.nf_in && ((r_state == COUNTDOWN) || (r_state == GAME_OVER));
  assign w_timer_last = (r_state == COUNTDOWN) ? DIGIT_LAST : GO_LAST;

  // Clear exactly when the FSM below changes phase or rolls a countdown digit.
  always_comb begin
    w_timer_clr = 1'b0;
    case (r_state)
      START:     w_timer_clr = w_start_ev;
      COUNTDOWN: w_timer_clr = w_timer_tc;
      FIGHT:     w_timer_clr = w_p_dead || w_o_dead;
      GAME_OVER: w_timer_clr = w_start_ev || w_timer_tc;
      default:   w_timer_clr = 1'b0;
    endcase
  end

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_clr  (w_timer_clr),
    .i_inc  (w_timer_inc),
    .i_last (w_timer_last),
    .o_tc   (w_timer_tc)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state         <= START;
      r_display_start <= 1'b1;
      r_play_enable   <= 1'b0;
      r_countdown     <= 2'd0;
      r_health_reload <= 1'b0;
      r_winner        <= WIN_NONE;
    end else begin
      r_health_reload <= 1'b0;
      case (r_state)
        START: begin
          if (w_start_ev) begin
            r_state         <= COUNTDOWN;
            r_display_start <= 1'b0;
            r_play_enable   <= 1'b0;
            r_countdown     <= CD_INIT;
            r_health_reload <= 1'b1;
            r_winner        <= WIN_NONE;
          end
        end
        COUNTDOWN: begin
          if (w_timer_tc) begin
            if (r_countdown == 2'd1) begin
              r_state       <= FIGHT;
              r_play_enable <= 1'b1;
            end
            r_countdown <= r_countdown - 2'd1;
          end
        end
        FIGHT: begin
          // Health outranks a pause arriving on the same cycle.
          if (w_p_dead || w_o_dead) begin
            r_state       <= GAME_OVER;
            r_play_enable <= 1'b0;
            if (w_p_dead && w_o_dead) r_winner <= WIN_DRAW;
            else if (w_o_dead)        r_winner <= WIN_PLAYER;
            else                      r_winner <= WIN_OPP;
          end else if (w_pause_ev) begin
            r_state       <= PAUSED;
            r_play_enable <= 1'b0;
          end
        end
        PAUSED: begin
          if (w_pause_ev) begin
            r_state       <= FIGHT;
            r_play_enable <= 1'b1;
          end
        end
        GAME_OVER: begin
          if (w_start_ev) begin
            r_state         <= COUNTDOWN;
            r_display_start <= 1'b0;
            r_play_enable   <= 1'b0;
            r_countdown     <= CD_INIT;
            r_health_reload <= 1'b1;
            r_winner        <= WIN_NONE;
          end else if (w_timer_tc) begin
            r_state         <= START;
            r_display_start <= 1'b1;
          end
        end
        default: begin
          r_state         <= START;
          r_display_start <= 1'b1;
          r_play_enable   <= 1'b0;
          r_countdown     <= 2'd0;
        end
      endcase
    end
  end

  assign bus.phase_out         = r_state;
  assign bus.display_start_out = r_display_start;
  assign bus.play_enable_out   = r_play_enable;
  assign bus.countdown_out     = r_countdown;
  assign bus.health_reload_out = r_health_reload;
  assign bus.winner_out        = r_winner;

endmodule

// File: doc/game_phase_controller.md
Name: game_phase_controller

Overview:
Top-level game sequencer. It decides what the display pipeline shows and when player/opponent gameplay logic may act. It consumes decoded IR remote codes, the new-frame strobe and both health counters. It drives the start-screen select, a countdown digit, the gameplay enable, health-reload pulses and winner/phase status. The display mux and health/saber logic consume its outputs instead of each decoding IR codes locally.

Parameters:
IR_START_A, 32'h20DF_5BA4, first remote code that leaves the start screen
IR_START_B, 32'h20DF_5AA5, second remote code that leaves the start screen
IR_PAUSE, 32'h20DF_10EF, code that toggles pause during play
COUNT_FROM, 3, first countdown digit shown (1..3)
FRAMES_PER_DIGIT, 60, nf_in pulses per countdown digit (>=1)
GAMEOVER_FRAMES, 180, nf_in pulses spent in GAME_OVER before returning to START (>=1)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
ir_in  in  32  last decoded IR code (held)
ir_valid_in  in  1  one-cycle strobe: ir_in holds a newly received code
nf_in  in  1  one-cycle new-frame strobe
player_health_in  in  3  player health, 0 = dead
opponent_health_in  in  3  opponent health, 0 = dead
phase_out  out  3  current state encoding (package enum)
display_start_out  out  1  1 = mux selects start screen
play_enable_out  out  1  1 = saber/attack/health logic may update
countdown_out  out  2  digit to overlay; 0 = no overlay
health_reload_out  out  1  one-cycle pulse: health blocks reload to full
winner_out  out  2  0 none, 1 player, 2 opponent, 3 draw

Behaviour:
- All outputs are registered. Reset values:
  - phase START, display_start_out 1
  - play_enable_out 0, countdown_out 0
  - health_reload_out 0, winner_out 0
  - frame counter 0
- An IR event is accepted only on a cycle where ir_valid_in = 1. A held ir_in never retriggers.
- State START:
  - display_start_out = 1.
  - An IR event matching IR_START_A or IR_START_B -> COUNTDOWN next cycle.
  - On that transition: health_reload_out pulses for exactly one cycle, countdown_out <= COUNT_FROM, frame counter <= 0, winner_out <= 0.
- State COUNTDOWN:
  - display_start_out 0, play_enable_out 0.
  - Each nf_in increments the frame counter.
  - When the counter reaches FRAMES_PER_DIGIT-1 and nf_in = 1: counter <= 0 and countdown_out decrements.
  - A decrement from 1 to 0 -> FIGHT. play_enable_out = 1 from the first FIGHT cycle.
  - IR events are ignored.
- State FIGHT:
  - play_enable_out 1, countdown_out 0.
  - Health check takes priority over pause in the same cycle.
  - Player health 0 and opponent health 0 in the same cycle -> winner 3.
  - Opponent health 0 only -> winner 1. Player health 0 only -> winner 2.
  - Any of these -> GAME_OVER: play_enable_out drops on the transition edge, frame counter <= 0.
  - Otherwise an IR_PAUSE event -> PAUSED.
- State PAUSED:
  - play_enable_out 0. All other outputs hold.
  - An IR_PAUSE event -> FIGHT.
  - Health is not evaluated while paused.
- State GAME_OVER:
  - play_enable_out 0, winner_out holds.
  - Counts nf_in pulses. When GAMEOVER_FRAMES pulses have been seen -> START, display_start_out 1, winner_out holds until the next start.
  - A start-code IR event in GAME_OVER skips straight to COUNTDOWN with the same actions as from START.
- Counter width: $clog2(max(FRAMES_PER_DIGIT, GAMEOVER_FRAMES)) + 1. The counter never wraps, because it is cleared on every state entry.
- nf_in and ir_valid_in in the same cycle: both are processed. A state transition clears the counter, so the counter increment is discarded.
- rst_in asserted in any state: START on the next edge with reset values. An in-flight health_reload_out pulse is cancelled.
- phase_out always equals the registered state. Latency from any qualifying event to its output change is 1 cycle.

Decomposition:
- Shared package game_pkg holds:
  - typedef enum logic [2:0] phase_t {START, COUNTDOWN, FIGHT, PAUSED, GAME_OVER}
  - winner encoding localparams WIN_NONE/WIN_PLAYER/WIN_OPP/WIN_DRAW
  - IR code constants, so the display module and input blocks share them.
- One natural sub-module: frame_timer. It counts nf_in with synchronous clear and terminal-count output, and is instantiated once and reused for both the countdown and game-over timing.

Test Plan:
- Reset; pulse ir_valid_in with ir_in = 32'h20DF_5BA4 -> next cycle phase COUNTDOWN, health_reload_out high for exactly 1 cycle, countdown_out 3, display_start_out 0.
- FRAMES_PER_DIGIT = 2; issue 6 nf_in pulses -> countdown_out steps 3,2,1 then phase FIGHT with play_enable_out 1 after the 6th pulse. An IR start event mid-countdown causes no change.
- In FIGHT, drive player 0 and opponent 0 on the same cycle, with an IR_PAUSE event on that cycle -> GAME_OVER, winner_out 3, not PAUSED.
- In FIGHT, IR_PAUSE event -> PAUSED, play_enable_out 0. Drop opponent health to 0 while paused -> no change. Second IR_PAUSE -> FIGHT, then GAME_OVER next cycle with winner 1.
- In GAME_OVER with GAMEOVER_FRAMES = 3 -> START after the 3rd nf_in, winner_out held. Repeat and send IR_START_B at the 1st frame -> COUNTDOWN with a reload pulse.
- Hold ir_in = start code with ir_valid_in low for 100 cycles in START -> stays START. Assert rst_in during COUNTDOWN -> START and all reset values next cycle.
